// File: rtl/adat_frame_writer.sv
// Serialises 8-channel 24-bit PCM frames MSB-first into a 1-bit circular frame RAM
// and publishes the slot of each completed frame to the ADAT encoder.
module adat_frame_writer #(
    parameter int CIRC_BUF_BITS = 3
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [23:0]                sample_i,
    input  logic                       sample_valid_i,
    input  logic                       sample_first_i,
    output logic                       sample_ready_o,
    output logic [CIRC_BUF_BITS+7:0]   ram_write_addr_o,
    output logic                       ram_data_o,
    output logic                       ram_we_o,
    output logic [CIRC_BUF_BITS-1:0]   last_good_frame_idx_o,
    output logic                       frame_done_o,
    output logic                       misalign_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t                     state_reg;
    state_t                     state_next;
    logic                       ready_en_reg;
    logic [23:0]                shift_reg;
    logic [4:0]                 bit_idx_reg;
    logic [2:0]                 chan_reg;
    logic [CIRC_BUF_BITS-1:0]   wframe_reg;
    logic [CIRC_BUF_BITS-1:0]   last_good_reg;
    logic                       frame_done_reg;
    logic                       misalign_reg;
    logic                       accept;

    // ready_en_reg holds off the handshake until the first clock after reset release
    assign accept = (state_reg == IDLE) && ready_en_reg && sample_valid_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = SHIFT;
            SHIFT:   if (bit_idx_reg == 5'd23) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ready_en_reg   <= 1'b0;
            shift_reg      <= '0;
            bit_idx_reg    <= '0;
            chan_reg       <= '0;
            wframe_reg     <= CIRC_BUF_BITS'(1);
            last_good_reg  <= '0;
            frame_done_reg <= 1'b0;
            misalign_reg   <= 1'b0;
        end else begin
            ready_en_reg   <= 1'b1;
            frame_done_reg <= 1'b0;
            misalign_reg   <= 1'b0;
            if (accept) begin
                shift_reg   <= sample_i;
                bit_idx_reg <= '0;
                // A new frame start mid-frame restarts the same write slot
                if (sample_first_i && (chan_reg != 3'd0)) begin
                    chan_reg     <= 3'd0;
                    misalign_reg <= 1'b1;
                end
            end else if (state_reg == SHIFT) begin
                shift_reg   <= {shift_reg[22:0], 1'b0};
                bit_idx_reg <= bit_idx_reg + 5'd1;
                if (bit_idx_reg == 5'd23) begin
                    bit_idx_reg <= '0;
                    if (chan_reg == 3'd7) begin
                        chan_reg       <= 3'd0;
                        last_good_reg  <= wframe_reg;
                        wframe_reg     <= wframe_reg + CIRC_BUF_BITS'(1);
                        frame_done_reg <= 1'b1;
                    end else begin
                        chan_reg <= chan_reg + 3'd1;
                    end
                end
            end
        end
    end

    // Write-side outputs are pure decodes of registers, forced to zero while idle
    assign sample_ready_o        = (state_reg == IDLE) && ready_en_reg;
    assign ram_we_o              = (state_reg == SHIFT);
    assign ram_data_o            = ram_we_o & shift_reg[23];
    assign ram_write_addr_o      = ram_we_o ? {wframe_reg, chan_reg, bit_idx_reg} : '0;
    assign last_good_frame_idx_o = last_good_reg;
    assign frame_done_o          = frame_done_reg;
    assign misalign_o            = misalign_reg;

endmodule

// File: tb/tb_adat_frame_writer.sv
// Randomised bench for adat_frame_writer with a per-cycle reference model of the RAM write stream.
module tb_adat_frame_writer;

    localparam int CBB = 3;
    localparam int AW  = CBB + 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [23:0]     sample;
    logic            valid;
    logic            first;
    logic            sample_ready_o;
    logic [AW-1:0]   ram_write_addr_o;
    logic            ram_data_o;
    logic            ram_we_o;
    logic [CBB-1:0]  last_good_frame_idx_o;
    logic            frame_done_o;
    logic            misalign_o;

    always #5 clk = ~clk;

    adat_frame_writer #(.CIRC_BUF_BITS(CBB)) dut (
        .clk_i                 (clk),
        .rst_ni                (rst_n),
        .sample_i              (sample),
        .sample_valid_i        (valid),
        .sample_first_i        (first),
        .sample_ready_o        (sample_ready_o),
        .ram_write_addr_o      (ram_write_addr_o),
        .ram_data_o            (ram_data_o),
        .ram_we_o              (ram_we_o),
        .last_good_frame_idx_o (last_good_frame_idx_o),
        .frame_done_o          (frame_done_o),
        .misalign_o            (misalign_o)
    );

    typedef struct {
        logic [AW-1:0] a;
        logic          d;
    } wr_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    wr_t  exp_q[$];
    int   m_wframe = 1;
    int   m_chan = 0;
    int   lg_exp = 0;
    int   lg_pend = 0;
    int   fd_cyc = -1;
    int   mis_cyc = -1;
    bit   m_rdy = 1'b0;
    int   acc_cnt = 0;
    int   we_cnt = 0;
    int   mis_cnt = 0;
    int   fd_cnt = 0;
    int   lg_hist[$];
    logic tb_ram [0:(1<<AW)-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, expv);
        end
    endtask

    always @(posedge clk) cyc++;

    // Ready may only rise on the first clock edge after reset release
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_rdy = 1'b0;
        else        m_rdy = 1'b1;
    end

    always @(negedge clk) begin
        bit  we_e;
        bit  rdy_e;
        bit  fd_now;
        wr_t w;
        logic [CBB-1:0] wf;
        logic [2:0]     ch;
        if (!rst_n) begin
            exp_q.delete();
            m_wframe = 1;
            m_chan   = 0;
            lg_exp   = 0;
            fd_cyc   = -1;
            mis_cyc  = -1;
        end
        we_e  = (exp_q.size() != 0);
        rdy_e = m_rdy && !we_e;
        chk("ready", sample_ready_o, rdy_e);
        chk("we", ram_we_o, we_e);
        if (we_e) begin
            w = exp_q.pop_front();
            chk("addr", ram_write_addr_o, w.a);
            chk("data", ram_data_o, w.d);
        end
        if (!rst_n) begin
            chk("rst_addr", ram_write_addr_o, 0);
            chk("rst_data", ram_data_o, 0);
        end
        if (ram_we_o === 1'b1) begin
            we_cnt++;
            tb_ram[ram_write_addr_o] = ram_data_o;
            checks++;
            if (ram_write_addr_o[AW-1 -: CBB] == CBB'(lg_exp)) begin
                errors++;
                $display("FAIL write_slot cyc=%0d actual=%0d required!=%0d",
                         cyc, ram_write_addr_o[AW-1 -: CBB], lg_exp);
            end
        end
        fd_now = (cyc == fd_cyc);
        if (fd_now) begin
            lg_exp = lg_pend;
            lg_hist.push_back(lg_pend);
        end
        chk("frame_done", frame_done_o, fd_now);
        chk("last_good", last_good_frame_idx_o, lg_exp);
        chk("misalign", misalign_o, cyc == mis_cyc);
        if (misalign_o === 1'b1) mis_cnt++;
        if (frame_done_o === 1'b1) fd_cnt++;
        if (rst_n && rdy_e && valid) begin
            acc_cnt++;
            if (first && m_chan != 0) begin
                mis_cyc = cyc + 1;
                m_chan  = 0;
            end
            wf = CBB'(m_wframe);
            ch = 3'(m_chan);
            for (int i = 0; i < 24; i++) begin
                w.a = {wf, ch, 5'(i)};
                w.d = sample[23 - i];
                exp_q.push_back(w);
            end
            if (m_chan == 7) begin
                fd_cyc   = cyc + 25;
                lg_pend  = m_wframe;
                m_wframe = (m_wframe + 1) % (1 << CBB);
                m_chan   = 0;
            end else begin
                m_chan++;
            end
        end
    end

    task automatic send(input logic [23:0] s, input logic f, input bit junk);
        int start;
        start = acc_cnt;
        sample = s;
        first  = f;
        valid  = 1'b1;
        for (int k = 0; k < 200 && acc_cnt == start; k++) @(posedge clk);
        #1;
        if (acc_cnt == start) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout cyc=%0d actual=none required=accept", cyc);
        end
        if (junk) begin
            for (int k = 0; k < 20; k++) begin
                valid  = 1'($urandom);
                sample = 24'($urandom);
                first  = 1'($urandom);
                @(posedge clk);
                #1;
            end
            valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        valid = 1'b0;
        while (exp_q.size() != 0 && k < 400) begin
            @(posedge clk);
            k++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout cyc=%0d actual=%0d required=0", cyc, exp_q.size());
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] s4;
        logic [23:0] got;
        int we0;
        int mis0;
        int fd0;
        rst_n  = 1'b0;
        valid  = 1'b0;
        sample = '0;
        first  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", sample_ready_o, 0);
        chk("rst_we", ram_we_o, 0);
        chk("rst_lg", last_good_frame_idx_o, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_rst", sample_ready_o, 1);

        // Directed first frame with valid held high
        lg_hist.delete();
        we0 = we_cnt;
        send(24'h800001, 1'b1, 1'b0);
        for (int c = 2; c <= 8; c++) send(24'(c), 1'b0, 1'b0);
        wait_idle();
        chk("t1_writes", we_cnt - we0, 192);
        chk("t1_ch0_b0", tb_ram[{3'd1, 3'd0, 5'd0}], 1);
        chk("t1_ch0_b23", tb_ram[{3'd1, 3'd0, 5'd23}], 1);
        chk("t1_ch0_b5", tb_ram[{3'd1, 3'd0, 5'd5}], 0);
        chk("t1_ch1_b22", tb_ram[{3'd1, 3'd1, 5'd22}], 1);
        chk("t1_ch1_b23", tb_ram[{3'd1, 3'd1, 5'd23}], 0);
        chk("t1_lg", last_good_frame_idx_o, 1);

        // Nine more back-to-back random frames wrap the slot index
        for (int f = 0; f < 9; f++)
            for (int c = 0; c < 8; c++)
                send(24'($urandom), (c == 0) ? 1'($urandom) : 1'b0, 1'b0);
        wait_idle();
        chk("wrap_count", lg_hist.size(), 10);
        for (int i = 0; i < 10 && i < lg_hist.size(); i++)
            chk("wrap_seq", lg_hist[i], (i + 1) % 8);

        // Realignment from a fresh reset
        do_reset();
        mis0 = mis_cnt;
        fd0  = fd_cnt;
        for (int c = 0; c < 3; c++) send(24'($urandom), c == 0, 1'b0);
        s4 = 24'($urandom);
        send(s4, 1'b1, 1'b0);
        wait_idle();
        chk("realign_pulse", mis_cnt - mis0, 1);
        chk("realign_no_fd", fd_cnt - fd0, 0);
        for (int c = 0; c < 7; c++) send(24'($urandom), 1'b0, 1'b0);
        wait_idle();
        got = '0;
        for (int b = 0; b < 24; b++) got[23 - b] = tb_ram[{3'd1, 3'd0, 5'(b)}];
        chk("realign_ch0", got, s4);
        chk("realign_lg", last_good_frame_idx_o, 1);
        chk("realign_fd", fd_cnt - fd0, 1);

        // Backpressure: junk on the inputs while shifting
        we0 = we_cnt;
        for (int c = 0; c < 8; c++) send(24'($urandom), c == 0, 1'b1);
        wait_idle();
        chk("bp_writes", we_cnt - we0, 192);
        chk("bp_lg", last_good_frame_idx_o, 2);

        // Reset at bit 10 of channel 5
        for (int c = 0; c < 6; c++) send(24'($urandom), c == 0, 1'b0);
        valid = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_we", ram_we_o, 0);
        chk("midrst_lg", last_good_frame_idx_o, 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 0; c < 8; c++) send(24'($urandom), c == 0, 1'b0);
        wait_idle();
        chk("midrst_next_lg", last_good_frame_idx_o, 1);

        // Random gaps, junk and occasional early frame starts
        for (int n = 0; n < 30; n++) begin
            send(24'($urandom), (n == 0) || ($urandom_range(0, 7) == 0), 1'($urandom));
            valid = 1'b0;
            repeat ($urandom_range(0, 20)) @(posedge clk);
            #1;
        end
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/adat_frame_writer.md
Name: adat_frame_writer

Overview:
- Upstream neighbour of the ADAT encoder. Accepts 24-bit PCM samples, 8 channels per frame, over a valid/ready stream from the USB audio path.
- Serialises each sample MSB-first into the 1-bit-wide circular frame RAM, at address {frame, channel, bit}.
- Publishes the index of each completed frame on last_good_frame_idx_o. The encoder latches that index at its next frame boundary.

Parameters:
- CIRC_BUF_BITS, 3, log2 of the number of frame slots in the circular RAM. Must match the encoder.

Ports:
- clk_i  in  1  system clock (ADAT bit clock domain)
- rst_ni  in  1  asynchronous active-low reset
- sample_i  in  24  PCM sample, two's complement, bit 23 = MSB
- sample_valid_i  in  1  sample_i / sample_first_i valid
- sample_first_i  in  1  qualifies sample_i as channel 0 of a new frame
- sample_ready_o  out  1  block can accept a sample this cycle
- ram_write_addr_o  out  CIRC_BUF_BITS+8  {frame[CIRC_BUF_BITS-1:0], channel[2:0], bit_idx[4:0]}
- ram_data_o  out  1  bit to write
- ram_we_o  out  1  write strobe, one bit per cycle
- last_good_frame_idx_o  out  CIRC_BUF_BITS  slot of the most recently completed frame
- frame_done_o  out  1  one-cycle pulse when last_good_frame_idx_o updates
- misalign_o  out  1  one-cycle pulse when a partial frame is discarded

Behaviour:
- Reset (async assert, sync release): all outputs 0. State IDLE, channel counter 0, write frame 1, shift register 0. sample_ready_o goes high the first clock after rst_ni deasserts.
- Clock and reset are fixed as above: single clock clk_i, asynchronous active-low reset rst_ni.
- States: IDLE, SHIFT.
- IDLE:
  - sample_ready_o = 1, ram_we_o = 0.
  - Handshake completes when sample_valid_i & sample_ready_o. On that edge: latch sample_i into the shift register, clear bit_idx, go to SHIFT.
- Realignment, evaluated at accept:
  - sample_first_i = 1 with channel counter != 0: discard the partial frame and treat this sample as channel 0 of the same write frame, which is overwritten. misalign_o pulses on the cycle after the accept.
  - sample_first_i = 0 with channel counter == 0: accepted as channel 0, no pulse.
- SHIFT:
  - sample_ready_o = 0.
  - Each cycle: ram_we_o = 1, ram_data_o = shift register MSB, address = {write_frame, channel, bit_idx}. Shift left; bit_idx increments 0..23.
  - bit_idx 0 carries sample bit 23; bit_idx 23 carries bit 0. This matches the encoder's MSB-first read order.
  - After the bit_idx 23 write, return to IDLE. Channel counter increments mod 8.
- Latency: accept at edge N; writes on cycles N+1..N+24; sample_ready_o high again on cycle N+25.
- Throughput: 1 sample per 25 cycles, so 200 cycles per frame, which fits within the 256-cycle ADAT frame.
- Frame completion (bit 23 of channel 7 written on cycle N+24): on cycle N+25,
  - last_good_frame_idx_o = completed write_frame;
  - frame_done_o = 1 for one cycle;
  - write_frame increments mod 2^CIRC_BUF_BITS (wraps from all-ones to 0);
  - channel counter returns to 0.
- last_good_frame_idx_o is never updated for a partial or discarded frame.
- Writes never target slot last_good_frame_idx_o: the write frame is always last_good + 1 mod 2^CIRC_BUF_BITS.
- sample_valid_i during SHIFT is ignored. The upstream holds data until ready; no sample is lost or double-accepted.
- sample_i and sample_first_i are sampled only at accept. Changes during SHIFT have no effect.
- Reset mid-SHIFT: writes stop immediately (ram_we_o = 0 asynchronously) and the partial frame is abandoned. last_good returns to 0 and write frame to 1. Consequently the encoder sees no new frame until a complete frame is written.
- All outputs are registered. No combinational path from inputs to outputs except sample_ready_o, which is a state decode.

Test Plan:
- Reset release, then 8 samples 0x800001, 0x000002 .. 0x000008 with sample_first_i on the first and valid held high.
  - Required: 192 writes, exactly one per cycle during SHIFT.
  - Channel 0: addr {1,0,0} data 1, addr {1,0,23} data 1, all others 0.
  - Frame: last_good_frame_idx_o becomes 1 with frame_done_o pulse one cycle after the final write; next frame writes slot 2.
- Throughput: valid held continuously.
  - Required: sample_ready_o high exactly 1 cycle in every 25; accept-to-first-write latency 1 cycle.
- Wrap: stream 9 full frames.
  - Required: last_good sequence 1,2,...,7,0,1; write slot never equals current last_good.
- Realign: 3 samples, then a 4th with sample_first_i = 1.
  - Required: misalign_o pulses once, 4th sample written at channel 0 of slot 1, no frame_done_o.
  - Then complete 7 more: last_good = 1.
- Backpressure: toggle sample_valid_i and change sample_i during SHIFT.
  - Required: RAM contents match only the accepted samples; no extra ram_we_o cycles.
- Async reset asserted at bit_idx 10 of channel 5.
  - Required: ram_we_o drops the same cycle; last_good = 0.
  - Next full frame publishes slot 1.
